// File: rtl/core_pkg.sv
// Shared constants for the write-back stage: WB bundle bit map, widths, FSM encoding.
// Latency: n/a (definitions only).
// Backpressure: n/a (definitions only).
package core_pkg;

  // Bit positions inside the WB control bundle
  localparam int WB_REGWRITE  = 0;
  localparam int WB_MEMTOREG  = 1;
  localparam int WB_PAIRWRITE = 2;
  localparam int WB_OUTPORT   = 3;

  localparam int REG_ADDR_W = 3;
  localparam int DATA_W     = 16;

  // Write-back FSM encoding
  localparam logic [0:0] ST_IDLE    = 1'b0;
  localparam logic [0:0] ST_PAIR_HI = 1'b1;

endpackage

// File: rtl/regfile_8x16.sv
// General register file: one write port, two combinational read ports with write-through.
// Latency: write visible on read ports in the same cycle (bypass), stored at next posedge.
// Backpressure: none; a write is accepted every cycle we is high.
module regfile_8x16
  import core_pkg::*;
#(
  parameter int NumRegs = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic [REG_ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0]     wdata,
  input  logic [REG_ADDR_W-1:0] raddr_a,
  input  logic [REG_ADDR_W-1:0] raddr_b,
  output logic [DATA_W-1:0]     rdata_a,
  output logic [DATA_W-1:0]     rdata_b
);

  logic [DATA_W-1:0] regs [NumRegs];

  // Register storage: synchronous clear, single write port
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NumRegs; i++) begin
        regs[i] <= '0;
      end
    end else if (we) begin
      regs[waddr] <= wdata;
    end
  end

  // Read ports: a write landing this cycle to the same address wins over stored value
  always_comb begin
    rdata_a = (we && (raddr_a == waddr)) ? wdata : regs[raddr_a];
    rdata_b = (we && (raddr_b == waddr)) ? wdata : regs[raddr_b];
  end

endmodule

// File: rtl/wb_stage_regfile.sv
// Write-back stage: selects result, commits to the register file, splits 32-bit loads into a register pair.
// Latency: 1 cycle for normal writes; 2 cycles for pair writes (lo then hi); output port registered 1 cycle.
// Backpressure: o_stall holds the MEM/WB buffer during the first cycle of a pair write.
module wb_stage_regfile
  import core_pkg::*;
#(
  parameter int WbSize  = 4,
  parameter int NumRegs = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [WbSize-1:0]     i_WB,
  input  logic [31:0]           i_MemData,
  input  logic [DATA_W-1:0]     i_alu,
  input  logic [REG_ADDR_W-1:0] i_Rdst,
  input  logic [REG_ADDR_W-1:0] i_RsrcA,
  input  logic [REG_ADDR_W-1:0] i_RsrcB,
  output logic [DATA_W-1:0]     o_RdataA,
  output logic [DATA_W-1:0]     o_RdataB,
  output logic                  o_stall,
  output logic                  o_fwd_valid,
  output logic [REG_ADDR_W-1:0] o_fwd_Rdst,
  output logic [DATA_W-1:0]     o_fwd_data,
  output logic [DATA_W-1:0]     o_out_port,
  output logic                  o_out_valid
);

  logic [0:0]            state;
  logic [DATA_W-1:0]     hi_data;
  logic [REG_ADDR_W-1:0] hi_dst;

  logic                  in_idle;
  logic                  regwrite;
  logic                  memtoreg;
  logic                  pairwrite;
  logic                  outport;
  logic                  pair_start;
  logic                  we;
  logic [REG_ADDR_W-1:0] waddr;
  logic [DATA_W-1:0]     wdata;

  assign in_idle    = (state == ST_IDLE);
  assign regwrite   = i_WB[WB_REGWRITE];
  assign memtoreg   = i_WB[WB_MEMTOREG];
  assign pairwrite  = i_WB[WB_PAIRWRITE];
  assign outport    = i_WB[WB_OUTPORT];
  assign pair_start = in_idle && regwrite && pairwrite;

  // Stall depends only on state and WB bits so it settles early in the cycle
  assign o_stall = pair_start;

  // Write-port select: lo half / normal result in IDLE, latched hi half in PAIR_HI
  always_comb begin
    we    = 1'b0;
    waddr = '0;
    wdata = '0;
    if (in_idle) begin
      if (regwrite) begin
        we    = 1'b1;
        waddr = i_Rdst;
        // Pair writes always take memory data, whatever MemToReg says
        wdata = (pairwrite || memtoreg) ? i_MemData[15:0] : i_alu;
      end
    end else begin
      we    = 1'b1;
      waddr = hi_dst;
      wdata = hi_data;
    end
  end

  assign o_fwd_valid = we;
  assign o_fwd_Rdst  = waddr;
  assign o_fwd_data  = wdata;

  // Pair FSM and hi-half latch; destination wraps R7 -> R0 through 3-bit overflow
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      hi_data <= '0;
      hi_dst  <= '0;
    end else if (in_idle) begin
      if (pair_start) begin
        state   <= ST_PAIR_HI;
        hi_data <= i_MemData[31:16];
        hi_dst  <= i_Rdst + 3'd1;
      end
    end else begin
      state <= ST_IDLE;
    end
  end

  // Output port capture; only honoured in IDLE since PAIR_HI sees a held, already-handled bundle
  always_ff @(posedge clk) begin
    if (rst) begin
      o_out_port  <= '0;
      o_out_valid <= 1'b0;
    end else if (in_idle && outport) begin
      o_out_port  <= i_alu;
      o_out_valid <= 1'b1;
    end else begin
      o_out_valid <= 1'b0;
    end
  end

  regfile_8x16 #(
    .NumRegs(NumRegs)
  ) u_regfile (
    .clk    (clk),
    .rst    (rst),
    .we     (we),
    .waddr  (waddr),
    .wdata  (wdata),
    .raddr_a(i_RsrcA),
    .raddr_b(i_RsrcB),
    .rdata_a(o_RdataA),
    .rdata_b(o_RdataB)
  );

endmodule

// File: tb/tb_wb_stage_regfile.sv
// Directed bench for the write-back stage and register file.
// Latency: inputs driven 1ns after posedge, outputs checked after settling.
// Backpressure: stall checked directly against expected pair-write sequencing.
module tb_wb_stage_regfile;

  logic        clk;
  logic        rst;
  logic [3:0]  i_WB;
  logic [31:0] i_MemData;
  logic [15:0] i_alu;
  logic [2:0]  i_Rdst;
  logic [2:0]  i_RsrcA;
  logic [2:0]  i_RsrcB;
  logic [15:0] o_RdataA;
  logic [15:0] o_RdataB;
  logic        o_stall;
  logic        o_fwd_valid;
  logic [2:0]  o_fwd_Rdst;
  logic [15:0] o_fwd_data;
  logic [15:0] o_out_port;
  logic        o_out_valid;

  int checks = 0;
  int passes = 0;
  int fails  = 0;

  wb_stage_regfile #(.WbSize(4), .NumRegs(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .i_WB       (i_WB),
    .i_MemData  (i_MemData),
    .i_alu      (i_alu),
    .i_Rdst     (i_Rdst),
    .i_RsrcA    (i_RsrcA),
    .i_RsrcB    (i_RsrcB),
    .o_RdataA   (o_RdataA),
    .o_RdataB   (o_RdataB),
    .o_stall    (o_stall),
    .o_fwd_valid(o_fwd_valid),
    .o_fwd_Rdst (o_fwd_Rdst),
    .o_fwd_data (o_fwd_data),
    .o_out_port (o_out_port),
    .o_out_valid(o_out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reads a register through both ports while no write is in flight
  task automatic rd(input string tag, input logic [2:0] a, input logic [15:0] exp);
    i_RsrcA = a;
    i_RsrcB = a;
    #1;
    chk({tag, "_A"}, {16'h0, o_RdataA}, {16'h0, exp});
    chk({tag, "_B"}, {16'h0, o_RdataB}, {16'h0, exp});
  endtask

  initial begin
    rst = 1'b1; i_WB = 4'b0000; i_MemData = 32'h0; i_alu = 16'h0;
    i_Rdst = 3'd0; i_RsrcA = 3'd0; i_RsrcB = 3'd0;

    // Reset, then read all registers
    tick(); tick();
    rst = 1'b0;
    #1;
    chk("rst_stall", {31'h0, o_stall}, 32'h0);
    chk("rst_out_valid", {31'h0, o_out_valid}, 32'h0);
    chk("rst_out_port", {16'h0, o_out_port}, 32'h0);
    chk("rst_fwd_valid", {31'h0, o_fwd_valid}, 32'h0);
    for (int a = 0; a < 8; a++) begin
      rd("rst_reg", 3'(a), 16'h0000);
    end

    // ALU write with same-cycle bypass
    i_WB = 4'b0001; i_alu = 16'h1234; i_Rdst = 3'd3; i_RsrcA = 3'd3; i_RsrcB = 3'd0;
    #1;
    chk("alu_bypass_A", {16'h0, o_RdataA}, 32'h1234);
    chk("alu_bypass_B_other", {16'h0, o_RdataB}, 32'h0);
    chk("alu_fwd_valid", {31'h0, o_fwd_valid}, 32'h1);
    chk("alu_fwd_rdst", {29'h0, o_fwd_Rdst}, 32'h3);
    chk("alu_stall", {31'h0, o_stall}, 32'h0);
    tick();
    i_WB = 4'b0000;
    rd("alu_r3", 3'd3, 16'h1234);
    chk("idle_fwd_valid", {31'h0, o_fwd_valid}, 32'h0);
    chk("idle_fwd_data", {16'h0, o_fwd_data}, 32'h0);

    // Memory write selects low half of memory data
    i_WB = 4'b0011; i_MemData = 32'hDEAD_BEEF; i_alu = 16'h5555; i_Rdst = 3'd2;
    #1;
    chk("mem_fwd_data", {16'h0, o_fwd_data}, 32'hBEEF);
    tick();
    i_WB = 4'b0000;
    rd("mem_r2", 3'd2, 16'hBEEF);

    // Pair write with wrap-around; MemToReg clear but memory data still used
    i_WB = 4'b0101; i_MemData = 32'hCAFE_F00D; i_alu = 16'h1111; i_Rdst = 3'd7;
    i_RsrcA = 3'd0; i_RsrcB = 3'd7;
    #1;
    chk("pair1_stall", {31'h0, o_stall}, 32'h1);
    chk("pair1_fwd_rdst", {29'h0, o_fwd_Rdst}, 32'h7);
    chk("pair1_fwd_data", {16'h0, o_fwd_data}, 32'hF00D);
    tick();
    chk("pair2_stall", {31'h0, o_stall}, 32'h0);
    chk("pair2_fwd_valid", {31'h0, o_fwd_valid}, 32'h1);
    chk("pair2_fwd_rdst", {29'h0, o_fwd_Rdst}, 32'h0);
    chk("pair2_fwd_data", {16'h0, o_fwd_data}, 32'hCAFE);
    chk("pair2_bypass_r0", {16'h0, o_RdataA}, 32'hCAFE);
    chk("pair2_r7", {16'h0, o_RdataB}, 32'hF00D);
    tick();
    i_WB = 4'b0000;
    rd("pair_r7", 3'd7, 16'hF00D);
    rd("pair_r0", 3'd0, 16'hCAFE);
    rd("pair_r1_untouched", 3'd1, 16'h0000);

    // PairWrite without RegWrite does nothing
    i_WB = 4'b0100; i_Rdst = 3'd5;
    #1;
    chk("nowr_stall", {31'h0, o_stall}, 32'h0);
    chk("nowr_fwd_valid", {31'h0, o_fwd_valid}, 32'h0);
    tick();

    // Reset during PAIR_HI: hi half dropped, everything cleared
    i_WB = 4'b0101; i_MemData = 32'hAAAA_BBBB; i_Rdst = 3'd4;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0; i_WB = 4'b0000;
    #1;
    chk("midrst_stall", {31'h0, o_stall}, 32'h0);
    rd("midrst_r4", 3'd4, 16'h0000);
    rd("midrst_r5", 3'd5, 16'h0000);
    rd("midrst_r3", 3'd3, 16'h0000);
    // Back in IDLE: a normal write targets i_Rdst, not a stale hi destination
    i_WB = 4'b0001; i_alu = 16'hABCD; i_Rdst = 3'd6;
    #1;
    chk("midrst_idle_rdst", {29'h0, o_fwd_Rdst}, 32'h6);
    chk("midrst_idle_data", {16'h0, o_fwd_data}, 32'hABCD);
    tick();
    i_WB = 4'b0000;

    // Output port combined with a register write
    i_WB = 4'b1001; i_alu = 16'h00FF; i_Rdst = 3'd1;
    #1;
    chk("out_pre_valid", {31'h0, o_out_valid}, 32'h0);
    tick();
    i_WB = 4'b0000;
    #1;
    chk("out_port", {16'h0, o_out_port}, 32'h00FF);
    chk("out_valid", {31'h0, o_out_valid}, 32'h1);
    rd("out_r1", 3'd1, 16'h00FF);
    tick();
    chk("out_valid_pulse_end", {31'h0, o_out_valid}, 32'h0);
    chk("out_port_hold", {16'h0, o_out_port}, 32'h00FF);

    // Output port on a pair write acts once; held bundle in PAIR_HI is ignored
    i_WB = 4'b1101; i_alu = 16'h0BAD; i_MemData = 32'h1234_5678; i_Rdst = 3'd5;
    tick();
    chk("pairout_valid1", {31'h0, o_out_valid}, 32'h1);
    chk("pairout_port", {16'h0, o_out_port}, 32'h0BAD);
    i_alu = 16'h7777;
    tick();
    chk("pairout_valid2", {31'h0, o_out_valid}, 32'h0);
    chk("pairout_port_kept", {16'h0, o_out_port}, 32'h0BAD);
    i_WB = 4'b0000;
    rd("pairout_r5", 3'd5, 16'h5678);
    rd("pairout_r6", 3'd6, 16'h1234);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
